aes_input_loader: RTL
=====================

AES_INPUT_LOADER -- requirements
Module: aes_input_loader

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low (`clk`, `rst_n`).
REQ-002 The block SHALL have parameter `IDLE_TIMEOUT`, default 255, giving the stall cycles allowed mid-frame before abort; 0 disables the timeout.
REQ-003 The block SHALL have port `clk`, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port `rst_n`, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port `sel`, input, 2 bits: key size; 0 = 128, 1 = 192, 2/3 = 256.
REQ-006 The block SHALL have port `in_data`, input, 8 bits: serial byte stream.
REQ-007 The block SHALL have port `in_valid`, input, 1 bit: `in_data` is valid.
REQ-008 The block SHALL have port `in_ready`, output, 1 bit: loader accepts a byte this cycle.
REQ-009 The block SHALL have port `key_keep`, input, 1 bit: reuse the stored key for this frame (only with REQ-029).
REQ-010 The block SHALL have port `blk_data`, output, 128 bits: assembled plaintext block.
REQ-011 The block SHALL have port `blk_key`, output, 256 bits: assembled key, left-aligned.
REQ-012 The block SHALL have port `blk_nk`, output, 2 bits: `sel` value latched for this frame.
REQ-013 The block SHALL have port `blk_valid`, output, 1 bit: block and key are ready for the AES core.
REQ-014 The block SHALL have port `blk_ready`, input, 1 bit: the AES core takes the block.
REQ-015 The block SHALL have port `err`, output, 1 bit: one-cycle pulse on a frame abort.

Function
REQ-016 The block SHALL implement four states:
- IDLE: `in_ready`=1.
- KEY: `in_ready`=1.
- DATA: `in_ready`=1.
- HOLD: `in_ready`=0, `blk_valid`=1.
REQ-017 A byte SHALL be accepted only on a cycle with `in_valid` & `in_ready`.
REQ-018 A byte accepted in IDLE SHALL start a frame:
- `sel` is latched into `blk_nk`.
- The byte counter is cleared.
- `blk_key` and `blk_data` are zeroed.
- The byte is stored as key byte 0.
- Next state is KEY.
REQ-019 The frame key length SHALL be 16, 24 or 32 bytes, set by the latched `blk_nk`; changes on `sel` mid-frame SHALL be ignored.
REQ-020 Key byte i SHALL be written to `blk_key[255-8i -: 8]`; for 128/192-bit keys the unused low bits SHALL stay 0.
REQ-021 After the last key byte, the block SHALL go to DATA; data byte j SHALL be written to `blk_data[127-8j -: 8]`, so the first byte is the MSB.
REQ-022 On acceptance of data byte 15, the next cycle SHALL be HOLD with `blk_valid`=1 (latency 1 cycle).
REQ-023 In HOLD, `blk_data`, `blk_key` and `blk_nk` SHALL be stable until `blk_valid` & `blk_ready`; the next cycle SHALL be IDLE.
REQ-024 `blk_ready` SHALL be ignored outside HOLD.
REQ-025 Timeout:
- A 16-bit stall counter counts cycles in KEY/DATA without an accepted byte.
- Any accepted byte clears it.
- When it reaches `IDLE_TIMEOUT` (≠0): `err`=1 for one cycle, the partial frame is discarded, outputs are zeroed, and the state goes to IDLE.
REQ-026 A byte accepted on the same cycle the stall counter would reach `IDLE_TIMEOUT` SHALL win: no abort occurs.

Reset
REQ-027 While `rst_n`=0 at a clock edge, the block SHALL set:
- State = IDLE.
- All outputs = 0, including `in_ready`=0.
- Counters = 0.
- The stored-key flag is cleared.
REQ-028 After reset is released, `in_ready` SHALL be 1 from the first clock edge with `rst_n`=1; reset mid-frame or in HOLD SHALL discard everything without `err`.

Configuration
REQ-029 Macro `AES_LOADER_KEY_REUSE_EN` behaviour:
- When defined: a key-reuse flag is set after every completed HOLD handshake.
- If `key_keep`=1 with the flag set, the first byte accepted in IDLE is data byte 0 and KEY is skipped.
- In that case `blk_key`/`blk_nk` retain the previous frame's values; `sel` is not relatched.
- When not defined: the `key_keep` port is present but ignored, and every frame loads a key.

Verification
REQ-030 Reset release, then bytes 00..0F with `sel`=0, then bytes 00,11,...,FF →
- `blk_valid`=1 exactly 1 cycle after the last byte.
- `blk_key[255:128]`=000102..0F, `blk_key[127:0]`=0.
- `blk_data`=00112233..EEFF, `blk_nk`=0.
REQ-031 `sel`=2 with 32 key bytes 00..1F and the same data; hold `blk_ready`=0 for 5 cycles → outputs stable and `in_ready`=0 for those 5 cycles; after `blk_ready`=1, IDLE and `in_ready`=1 on the next cycle.
REQ-032 `IDLE_TIMEOUT`=4, `sel`=1; send 10 key bytes, then `in_valid`=0 → `err` pulses on the 4th stall cycle, outputs are 0, and a fresh 24+16-byte frame completes correctly.
REQ-033 `sel` changes 0→2 after key byte 3 → the frame still takes 16 key bytes and `blk_nk`=0.
REQ-034 With `AES_LOADER_KEY_REUSE_EN` defined, a second frame with `key_keep`=1 sends 16 bytes only → `blk_valid` after those 16 bytes with the first frame's key; without the macro, the same stimulus leaves the block in DATA waiting.
REQ-035 Assert `rst_n`=0 in HOLD → the next cycle has `blk_valid`=0 and `err`=0.

Source files
------------

// File: rtl/aes_input_loader.sv
// Serial byte loader for an AES core: gathers a 16/24/32-byte key and a 16-byte block.
// Optional key reuse across frames is enabled by defining AES_LOADER_KEY_REUSE_EN.
module aes_input_loader #(
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   sel,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         key_keep,
    output logic [127:0] blk_data,
    output logic [255:0] blk_key,
    output logic [1:0]   blk_nk,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         err
);

`ifdef AES_LOADER_KEY_REUSE_EN
    localparam bit KeyReuseEn = 1'b1;
`else
    localparam bit KeyReuseEn = 1'b0;
`endif

    localparam logic [15:0] TimeoutCnt = 16'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StKey, StData, StHold} stateT;

    stateT       state;
    logic [4:0]  byteCnt;
    logic [15:0] stallCnt;
    logic        keyStored;

    logic       accept;
    logic       timeoutHit;
    logic [4:0] lastKeyIdx;

    assign accept     = in_valid & in_ready;
    assign timeoutHit = (TimeoutCnt != 16'd0) && ((stallCnt + 16'd1) == TimeoutCnt);

    always_comb begin
        unique case (blk_nk)
            2'd0:    lastKeyIdx = 5'd15;
            2'd1:    lastKeyIdx = 5'd23;
            default: lastKeyIdx = 5'd31;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            byteCnt   <= '0;
            stallCnt  <= '0;
            keyStored <= 1'b0;
            in_ready  <= 1'b0;
            blk_data  <= '0;
            blk_key   <= '0;
            blk_nk    <= '0;
            blk_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err      <= 1'b0;
            in_ready <= (state != StHold) || blk_ready;
            case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        byteCnt  <= 5'd1;
                        stallCnt <= '0;
                        // A reused key keeps blk_key/blk_nk; the first byte is then data byte 0
                        if (KeyReuseEn && key_keep && keyStored) begin
                            blk_data <= {in_data, 120'b0};
                            state    <= StData;
                        end else begin
                            blk_data <= '0;
                            blk_key  <= {in_data, 248'b0};
                            blk_nk   <= sel;
                            state    <= StKey;
                        end
                    end
                end
                StKey, StData: begin
                    if (accept) begin
                        stallCnt <= '0;
                        if (state == StKey) begin
                            blk_key[8'd255 - {byteCnt, 3'b000} -: 8] <= in_data;
                            if (byteCnt == lastKeyIdx) begin
                                byteCnt <= '0;
                                state   <= StData;
                            end else begin
                                byteCnt <= byteCnt + 5'd1;
                            end
                        end else begin
                            blk_data[7'd127 - {byteCnt[3:0], 3'b000} -: 8] <= in_data;
                            if (byteCnt == 5'd15) begin
                                byteCnt   <= '0;
                                blk_valid <= 1'b1;
                                in_ready  <= 1'b0;
                                state     <= StHold;
                            end else begin
                                byteCnt <= byteCnt + 5'd1;
                            end
                        end
                    end else if (timeoutHit) begin
                        err      <= 1'b1;
                        state    <= StIdle;
                        byteCnt  <= '0;
                        stallCnt <= '0;
                        blk_data <= '0;
                        blk_key  <= '0;
                        blk_nk   <= '0;
                    end else if (stallCnt != 16'hFFFF) begin
                        stallCnt <= stallCnt + 16'd1;
                    end
                end
                StHold: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        keyStored <= KeyReuseEn;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
